// File: rtl/rom_loader_pkg.sv
// Shared types and sizing for the ROM program loader.
// Optional checksum stage is enabled by defining ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;
    localparam int IDX_W      = 2;

endpackage

// File: rtl/loader_word_pack.sv
// Byte index counter and little-endian 32-bit pack register.
// Emits the packed word one cycle after the qualifying last byte.
module loader_word_pack
    import rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    input  logic              emit,
    output logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] next_word,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] sr;

    // First byte received ends up in the least significant lane
    assign next_word = {byte_in, sr[WORD_W-1:8]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx        <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= emit;
            if (byte_en) begin
                sr  <= next_word;
                idx <= idx + IDX_W'(1);
            end
            if (emit) begin
                word <= next_word;
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed image into the instruction ROM and holds the core in reset until done.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int ROM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rstn,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = ADDR_W + 1;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state;
    state_t            state_nxt;
    logic              ready_q;
    logic              ready_nxt;
    logic              accept;
    logic              emit;
    logic              last_len;
    logic              last_byte;
    logic              last_word;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] next_word;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_q;
    logic              err_q;

    assign accept    = rx_valid & ready_q;
    assign last_len  = idx == IDX_W'(LEN_BYTES - 1);
    assign last_byte = idx == IDX_W'(WORD_BYTES - 1);
    assign last_word = (word_cnt + CNT_W'(1)) == len_q;
    assign emit      = accept & (state == S_DATA) & last_byte;

    loader_word_pack u_pack (
        .clk        (clk),
        .rstn       (rstn),
        .byte_en    (accept),
        .byte_in    (rx_data),
        .emit       (emit),
        .idx        (idx),
        .next_word  (next_word),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum_q <= '0;
        end else if (accept && state == S_DATA) begin
            sum_q <= sum_q + rx_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LEN: begin
                if (accept && last_len) begin
                    if (next_word > 32'(ROM_DEPTH)) begin
                        state_nxt = S_ERR;
                    end else if (next_word == '0) begin
                        state_nxt = S_TAIL;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (emit && last_word) begin
                    state_nxt = S_TAIL;
                end
            end
            S_CHK: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_nxt = (rx_data == sum_q) ? S_DONE : S_ERR;
                end
`else
                state_nxt = S_ERR;
`endif
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
        ready_nxt = (state_nxt == S_LEN) ||
                    (state_nxt == S_DATA) ||
                    (state_nxt == S_CHK);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_LEN;
            ready_q  <= 1'b0;
            len_q    <= '0;
            word_cnt <= '0;
            waddr_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            // Released one cycle after S_DONE is reached
            done_q  <= state == S_DONE;
            err_q   <= state == S_ERR;
            if (accept && state == S_LEN && last_len) begin
                len_q <= next_word[CNT_W-1:0];
            end
            if (emit) begin
                waddr_q  <= word_cnt[ADDR_W-1:0];
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    assign rx_ready  = ready_q;
    assign rom_we    = word_valid;
    assign rom_waddr = waddr_q;
    assign rom_wdata = word;
    assign core_rstn = done_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule
